// File: rtl/div_pkg.sv
// Shared constants for the restoring divider: FSM state encoding and default operand width.
package div_pkg;

  localparam int DIV_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/div_step.sv
// One restoring shift-compare-subtract iteration, purely combinational (zero latency, no flow control).
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0] rem_in,
  input  logic           dvd_bit,
  input  logic [WIDTH:0] divisor,
  output logic [WIDTH:0] rem_out,
  output logic           q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH:0]   diff;

  // The partial remainder stays below the divisor, so when the subtract
  // succeeds the true difference fits in WIDTH+1 bits and modular wrap is exact.
  always_comb begin
    shifted = {rem_in, dvd_bit};
    q_bit   = (shifted >= {1'b0, divisor});
    diff    = shifted[WIDTH:0] - divisor;
    rem_out = q_bit ? diff : shifted[WIDTH:0];
  end

endmodule

// File: rtl/div_restoring.sv
// Restoring divider, signed/unsigned; done pulses WIDTH+2 cycles after start (2 for divide-by-zero).
// No backpressure: start is only honoured in IDLE and ignored while an operation is in flight.
module div_restoring
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] N,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST     = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [WIDTH:0] ONE_X    = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state;
  logic             launch;
  logic [WIDTH-1:0] n_q;
  logic [WIDTH-1:0] d_q;
  logic             sm_q;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH:0]   dmag;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   ext_n;
  logic [WIDTH:0]   ext_d;
  logic [WIDTH:0]   mag_n;
  logic [WIDTH:0]   mag_d;
  logic [WIDTH:0]   rem_nx;
  logic             q_bit;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic             q_neg;
  logic             r_neg;
  logic             ovf_c;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem),
    .dvd_bit (dvd[WIDTH-1]),
    .divisor (dmag),
    .rem_out (rem_nx),
    .q_bit   (q_bit)
  );

  // Sign-extend to WIDTH+1 bits before negating so the most-negative value has an exact magnitude.
  always_comb begin
    ext_n = {sm_q & n_q[WIDTH-1], n_q};
    ext_d = {sm_q & d_q[WIDTH-1], d_q};
    mag_n = ext_n[WIDTH] ? (~ext_n + ONE_X) : ext_n;
    mag_d = ext_d[WIDTH] ? (~ext_d + ONE_X) : ext_d;
    q_neg = sm_q & (n_q[WIDTH-1] ^ d_q[WIDTH-1]);
    r_neg = sm_q & n_q[WIDTH-1];
    q_mag = {dvd[WIDTH-2:0], q_bit};
    r_mag = rem_nx[WIDTH-1:0];
    q_fix = q_neg ? (~q_mag + ONE_W) : q_mag;
    r_fix = r_neg ? (~r_mag + ONE_W) : r_mag;
    ovf_c = sm_q & (n_q == MOST_NEG) & (d_q == {WIDTH{1'b1}});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      launch <= 1'b0;
      n_q    <= '0;
      d_q    <= '0;
      sm_q   <= 1'b0;
      rem    <= '0;
      dvd    <= '0;
      dmag   <= '0;
      cnt    <= '0;
      Q      <= '0;
      R      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      dbz    <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Operands are registered first; magnitudes are formed from the registered copy.
          if (launch) begin
            launch <= 1'b0;
            if (d_q == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
              Q     <= '1;
              R     <= n_q;
              dbz   <= 1'b1;
            end else begin
              state <= ST_RUN;
              busy  <= 1'b1;
              rem   <= {{WIDTH{1'b0}}, mag_n[WIDTH]};
              dvd   <= mag_n[WIDTH-1:0];
              dmag  <= mag_d;
              cnt   <= '0;
            end
          end else if (start) begin
            launch <= 1'b1;
            n_q    <= N;
            d_q    <= D;
            sm_q   <= signed_mode;
            dbz    <= 1'b0;
            ovf    <= 1'b0;
          end
        end
        ST_RUN: begin
          rem <= rem_nx;
          dvd <= {dvd[WIDTH-2:0], q_bit};
          cnt <= cnt + CNT_ONE;
          if (cnt == LAST) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            Q     <= q_fix;
            R     <= r_fix;
            ovf   <= ovf_c;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
